// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with a double-buffered
// load path, optional leading-zero blanking and per-digit decimal points.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);

  logic [PS_W-1:0]         r_prescaler;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_digit_en;

  logic                    w_tick;
  logic                    w_frame;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_blank_sel;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_encode = 7'b1000000;
      4'h1: seg_encode = 7'b1111001;
      4'h2: seg_encode = 7'b0100100;
      4'h3: seg_encode = 7'b0110000;
      4'h4: seg_encode = 7'b0011001;
      4'h5: seg_encode = 7'b0010010;
      4'h6: seg_encode = 7'b0000010;
      4'h7: seg_encode = 7'b1111000;
      4'h8: seg_encode = 7'b0000000;
      4'h9: seg_encode = 7'b0010000;
      4'hA: seg_encode = 7'b0001000;
      4'hB: seg_encode = 7'b0000011;
      4'hC: seg_encode = 7'b1000110;
      4'hD: seg_encode = 7'b0100001;
      4'hE: seg_encode = 7'b0000110;
      default: seg_encode = 7'b0001110;
    endcase
  endfunction

  assign w_tick  = (r_prescaler == PS_W'(SCAN_DIV - 1));
  assign w_frame = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // A digit is a leading zero when it and every more significant nibble are zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_d0
        assign w_blank[gi] = 1'b0;
      end else begin : g_dn
        assign w_blank[gi] = blank_lz && (r_disp_data[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp_data[4*i +: 4];
        w_dp_sel    = r_disp_dp[i];
        w_blank_sel = w_blank[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler   <= '0;
      r_idx         <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_pending     <= 1'b0;
      r_seg         <= 7'b1111111;
      r_dp          <= 1'b1;
      r_digit_en    <= '0;
    end else begin
      if (w_tick) begin
        r_prescaler <= '0;
        r_idx       <= w_frame ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_prescaler <= r_prescaler + PS_W'(1);
      end

      if (load) begin
        r_shadow_data <= data;
        r_shadow_dp   <= dp_in;
      end

      // A load coinciding with the frame boundary bypasses the shadow wait.
      if (w_frame) begin
        if (load) begin
          r_disp_data <= data;
          r_disp_dp   <= dp_in;
        end else if (r_pending) begin
          r_disp_data <= r_shadow_data;
          r_disp_dp   <= r_shadow_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end

      r_digit_en <= w_onehot;
      r_seg      <= w_blank_sel ? 7'b1111111 : seg_encode(w_nib);
      r_dp       <= w_blank_sel | ~w_dp_sel;
    end
  end

  assign seg_out  = r_seg;
  assign dp_out   = r_dp;
  assign digit_en = r_digit_en;
  assign pending  = r_pending;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, SCAN_DIV=4;
// frame boundaries fall on cycles that are multiples of 16 after reset release.
module tb_hex_display_scanner;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        pending;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data     (data),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg_out  (seg_out),
    .dp_out   (dp_out),
    .digit_en (digit_en),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int cur_digit();
    return ((cyc - 1) / 4) % 4;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; data = '0; dp_in = '0; blank_lz = 1'b0;
    #12;
    checks++; if (seg_out !== 7'b1111111) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg_out); end
    checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_out); end
    checks++; if (digit_en !== 4'b0000) begin failures++; $display("FAIL reset_en got=%b exp=0000", digit_en); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    $display("reset released");
  endtask

  task automatic test_scan();
    logic [3:0] exp_en;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_en = 4'b0001 << cur_digit();
      checks++; if (digit_en !== exp_en) begin failures++; $display("FAIL scan_en cyc=%0d got=%b exp=%b", cyc, digit_en, exp_en); end
      checks++; if (seg_out !== 7'b1000000) begin failures++; $display("FAIL scan_seg cyc=%0d got=%b exp=1000000", cyc, seg_out); end
      checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, dp_out); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL scan_pending cyc=%0d got=%b exp=0", cyc, pending); end
    end
    $display("scan: 20 cycles idle scan checked");
  endtask

  task automatic test_load();
    logic [6:0] tbl [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    logic [3:0] exp_en;
    step();
    load = 1'b1; data = 16'h1A3F; dp_in = 4'b0100;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL load_pending_set got=%b exp=1", pending); end
    for (int k = 23; k <= 32; k++) begin
      step();
      checks++; if (pending !== (cyc < 32)) begin failures++; $display("FAIL load_pending cyc=%0d got=%b exp=%b", cyc, pending, cyc < 32); end
      checks++; if (seg_out !== 7'b1000000) begin failures++; $display("FAIL load_old_seg cyc=%0d got=%b exp=1000000", cyc, seg_out); end
    end
    for (int k = 33; k <= 48; k++) begin
      step();
      exp_en = 4'b0001 << cur_digit();
      checks++; if (seg_out !== tbl[cur_digit()]) begin failures++; $display("FAIL load_seg cyc=%0d got=%b exp=%b", cyc, seg_out, tbl[cur_digit()]); end
      checks++; if (dp_out !== (cur_digit() != 2)) begin failures++; $display("FAIL load_dp cyc=%0d got=%b exp=%b", cyc, dp_out, cur_digit() != 2); end
      checks++; if (digit_en !== exp_en) begin failures++; $display("FAIL load_en cyc=%0d got=%b exp=%b", cyc, digit_en, exp_en); end
    end
    $display("load: 1A3F shown after frame boundary");
  endtask

  task automatic test_back_to_back();
    logic [6:0] tbl [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    logic exp_pend;
    for (int k = 49; k <= 64; k++) begin
      if (k == 50) begin load = 1'b1; data = 16'h1111; dp_in = 4'b0000; end
      if (k == 54) begin load = 1'b1; data = 16'h2222; dp_in = 4'b0000; end
      step();
      load = 1'b0;
      exp_pend = (k >= 50) && (k < 64);
      checks++; if (pending !== exp_pend) begin failures++; $display("FAIL b2b_pending cyc=%0d got=%b exp=%b", cyc, pending, exp_pend); end
      checks++; if (seg_out !== tbl[cur_digit()]) begin failures++; $display("FAIL b2b_old_seg cyc=%0d got=%b exp=%b", cyc, seg_out, tbl[cur_digit()]); end
    end
    for (int k = 65; k <= 80; k++) begin
      step();
      checks++; if (seg_out !== 7'b0100100) begin failures++; $display("FAIL b2b_seg cyc=%0d got=%b exp=0100100", cyc, seg_out); end
      checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL b2b_dp cyc=%0d got=%b exp=1", cyc, dp_out); end
    end
    $display("back_to_back: only 2222 displayed");
  endtask

  task automatic test_wrap_load();
    logic [6:0] tbl [4] = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};
    for (int k = 81; k <= 96; k++) begin
      if (k == 96) begin load = 1'b1; data = 16'hBEEF; dp_in = 4'b0000; end
      step();
      load = 1'b0;
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL wrap_pending cyc=%0d got=%b exp=0", cyc, pending); end
      checks++; if (seg_out !== 7'b0100100) begin failures++; $display("FAIL wrap_old_seg cyc=%0d got=%b exp=0100100", cyc, seg_out); end
    end
    for (int k = 97; k <= 112; k++) begin
      step();
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL wrap_pending2 cyc=%0d got=%b exp=0", cyc, pending); end
      checks++; if (seg_out !== tbl[cur_digit()]) begin failures++; $display("FAIL wrap_seg cyc=%0d got=%b exp=%b", cyc, seg_out, tbl[cur_digit()]); end
    end
    $display("wrap_load: BEEF shown on next frame");
  endtask

  task automatic test_blank_lz();
    logic [6:0] beef [4] = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};
    logic [6:0] t40 [4]  = '{7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111};
    logic [6:0] t00 [4]  = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
    for (int k = 113; k <= 128; k++) begin
      if (k == 113) blank_lz = 1'b1;
      if (k == 114) begin load = 1'b1; data = 16'h0040; dp_in = 4'b1100; end
      step();
      load = 1'b0;
      checks++; if (seg_out !== beef[cur_digit()]) begin failures++; $display("FAIL lz_beef_seg cyc=%0d got=%b exp=%b", cyc, seg_out, beef[cur_digit()]); end
    end
    for (int k = 129; k <= 144; k++) begin
      if (k == 130) begin load = 1'b1; data = 16'h0000; dp_in = 4'b0001; end
      step();
      load = 1'b0;
      checks++; if (seg_out !== t40[cur_digit()]) begin failures++; $display("FAIL lz_0040_seg cyc=%0d got=%b exp=%b", cyc, seg_out, t40[cur_digit()]); end
      checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL lz_0040_dp cyc=%0d got=%b exp=1", cyc, dp_out); end
    end
    for (int k = 145; k <= 166; k++) begin
      step();
      checks++; if (seg_out !== t00[cur_digit()]) begin failures++; $display("FAIL lz_0000_seg cyc=%0d got=%b exp=%b", cyc, seg_out, t00[cur_digit()]); end
      checks++; if (dp_out !== (cur_digit() != 0)) begin failures++; $display("FAIL lz_0000_dp cyc=%0d got=%b exp=%b", cyc, dp_out, cur_digit() != 0); end
    end
    blank_lz = 1'b0;
    step();
    checks++; if (seg_out !== 7'b1000000) begin failures++; $display("FAIL lz_release_seg cyc=%0d got=%b exp=1000000", cyc, seg_out); end
    $display("blank_lz: 0040 and 0000 blanking checked");
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_en;
    for (int k = 168; k <= 176; k++) begin
      if (k == 176) begin load = 1'b1; data = 16'h1234; dp_in = 4'b0000; end
      step();
      load = 1'b0;
    end
    step();
    checks++; if (seg_out !== 7'b0011001) begin failures++; $display("FAIL rst_pre_seg cyc=%0d got=%b exp=0011001", cyc, seg_out); end
    load = 1'b1; data = 16'h5678; dp_in = 4'b1111;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rst_pre_pending got=%b exp=1", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (seg_out !== 7'b1111111) begin failures++; $display("FAIL rst_async_seg got=%b exp=1111111", seg_out); end
    checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL rst_async_dp got=%b exp=1", dp_out); end
    checks++; if (digit_en !== 4'b0000) begin failures++; $display("FAIL rst_async_en got=%b exp=0000", digit_en); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rst_async_pending got=%b exp=0", pending); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_en = 4'b0001 << cur_digit();
      checks++; if (digit_en !== exp_en) begin failures++; $display("FAIL rst_post_en cyc=%0d got=%b exp=%b", cyc, digit_en, exp_en); end
      checks++; if (seg_out !== 7'b1000000) begin failures++; $display("FAIL rst_post_seg cyc=%0d got=%b exp=1000000", cyc, seg_out); end
      checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL rst_post_dp cyc=%0d got=%b exp=1", cyc, dp_out); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rst_post_pending cyc=%0d got=%b exp=0", cyc, pending); end
    end
    $display("reset_mid: pending data discarded, display back to 0000");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_wrap_load();
    test_blank_lz();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
